s27_array: RTL and testbench

//  Parametrised successor of the 3-flop s27 benchmark core: CHANNELS independent s27-function slices sharing one clock.

---
 rtl/iscas_seq_pkg.sv | 12 +
 rtl/s27_cell.sv | 53 +++++
 rtl/s27_array.sv | 95 +++++++++
 tb/tb_s27_array.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/iscas_seq_pkg.sv
// Shared constants for the s27 slice array: state layout and MISR polynomial.
// Imported by s27_cell and s27_array.
package iscas_seq_pkg;
  localparam int STATE_W = 3;
  localparam int S5_IDX = 0;
  localparam int S6_IDX = 1;
  localparam int S7_IDX = 2;
  // x^16 + x^12 + x^3 + 1
  localparam logic [15:0] MISR_POLY = 16'h1009;

  typedef logic [STATE_W-1:0] s27_state_t;
endpackage

// File: rtl/s27_cell.sv
// One s27 slice: three state flops with scan mux, hold enable and G17c.
// Ports: clk, rst (sync, high), se/si/so scan, en hold, g0-g3 in, g17c out.
module s27_cell
  import iscas_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic se,
  input  logic si,
  input  logic en,
  input  logic g0,
  input  logic g1,
  input  logic g2,
  input  logic g3,
  output logic so,
  output logic g17c
);

  s27_state_t st;
  logic g14, g12, g8, g15, g16;
  logic g9, g11, g10, g13;

  always_comb begin
    g14  = ~g0;
    g12  = ~(g1 | st[S7_IDX]);
    g8   = g14 & st[S6_IDX];
    g15  = g12 | g8;
    g16  = g3 | g8;
    g9   = ~(g16 & g15);
    g11  = ~(st[S5_IDX] | g9);
    g10  = ~(g14 | g11);
    g13  = ~(g2 | g12);
    g17c = ~g11;
  end

  // Scan order inside the slice: si -> S5 -> S6 -> S7 -> so.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0;
    end else if (se) begin
      st[S5_IDX] <= si;
      st[S6_IDX] <= st[S5_IDX];
      st[S7_IDX] <= st[S6_IDX];
    end else if (en) begin
      st[S5_IDX] <= g10;
      st[S6_IDX] <= g11;
      st[S7_IDX] <= g13;
    end
  end

  assign so = st[S7_IDX];

endmodule

// File: rtl/s27_array.sv
// CHANNELS independent s27 slices, full scan chain, optional G17 register.
// Ports: CK, RST (sync, high), GND/VDD ties, SE/SI/SO scan, EN, G0-G3, G17,
// SIG (only when ISCAS_MISR_EN is defined: output-signature MISR).
module s27_array
  import iscas_seq_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int OUT_REG  = 0,
  parameter int SIG_W    = 16
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                GND,
  input  logic                VDD,
  input  logic                SE,
  input  logic                SI,
  output logic                SO,
  input  logic [CHANNELS-1:0] EN,
  input  logic [CHANNELS-1:0] G0,
  input  logic [CHANNELS-1:0] G1,
  input  logic [CHANNELS-1:0] G2,
  input  logic [CHANNELS-1:0] G3,
`ifdef ISCAS_MISR_EN
  output logic [SIG_W-1:0]    SIG,
`endif
  output logic [CHANNELS-1:0] G17
);

  logic [CHANNELS:0]   sc;
  logic [CHANNELS-1:0] g17c;

  // Power ties are layout pass-throughs only.
  logic unused_ties;
  assign unused_ties = GND ^ VDD;

  assign sc[0] = SI;
  assign SO    = sc[CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    s27_cell u_cell (
      .clk  (CK),
      .rst  (RST),
      .se   (SE),
      .si   (sc[c]),
      .en   (EN[c]),
      .g0   (G0[c]),
      .g1   (G1[c]),
      .g2   (G2[c]),
      .g3   (G3[c]),
      .so   (sc[c+1]),
      .g17c (g17c[c])
    );
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [CHANNELS-1:0] g17r;
    always_ff @(posedge CK) begin
      if (RST) begin
        g17r <= '0;
      end else if (!SE) begin
        g17r <= g17c;
      end
    end
    assign G17 = g17r;
  end else begin : g_ocomb
    assign G17 = g17c;
  end

`ifdef ISCAS_MISR_EN
  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] fb;

  // Wide arrays wrap: output i lands on signature bit i mod SIG_W.
  always_comb begin
    fold = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fold[i % SIG_W] = fold[i % SIG_W] ^ g17c[i];
    end
  end

  assign fb = SIG[SIG_W-1] ? SIG_W'(MISR_POLY) : '0;

  always_ff @(posedge CK) begin
    if (RST) begin
      SIG <= '0;
    end else if (!SE) begin
      SIG <= {SIG[SIG_W-2:0], 1'b0} ^ fb ^ fold;
    end
  end
`else
  logic [SIG_W-1:0] unused_sig_w;
  assign unused_sig_w = '0;
`endif

endmodule

// File: tb/tb_s27_array.sv
// Scoreboard bench for s27_array: queue of expected outputs from a
// behavioural model, popped and compared by a separate monitor.
module tb_s27_array;
  localparam int N  = 4;
  localparam int CL = 3 * N;

  logic CK = 1'b0;
  logic RST, GND, VDD, SE, SI;
  logic [N-1:0] EN, G0, G1, G2, G3;
  logic SO, SO_R;
  logic [N-1:0] G17, G17_R;
`ifdef ISCAS_MISR_EN
  logic [15:0] SIG, SIG_R;
`endif

  always #5 CK = ~CK;

  s27_array #(.CHANNELS(N), .OUT_REG(0)) dut (
    .CK(CK), .RST(RST), .GND(GND), .VDD(VDD),
    .SE(SE), .SI(SI), .SO(SO), .EN(EN),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3),
`ifdef ISCAS_MISR_EN
    .SIG(SIG),
`endif
    .G17(G17)
  );

  s27_array #(.CHANNELS(N), .OUT_REG(1)) dut_r (
    .CK(CK), .RST(RST), .GND(GND), .VDD(VDD),
    .SE(SE), .SI(SI), .SO(SO_R), .EN(EN),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3),
`ifdef ISCAS_MISR_EN
    .SIG(SIG_R),
`endif
    .G17(G17_R)
  );

  typedef struct {
    logic         chk;
    logic [N-1:0] g17;
    logic [N-1:0] g17r;
    logic         so;
    logic [15:0]  sig;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Model: chain[k] in scan order; slice c holds S5,S6,S7 at 3c..3c+2.
  logic [CL-1:0] chain;
  logic [N-1:0]  m_g17r;
  logic [15:0]   m_sig;
  bit            m_known = 0;

  function automatic logic [3:0] s27f(input logic a0, a1, a2, a3,
                                      input logic s5, s6, s7);
    logic g14, g12, g8, g15, g16, g9, g11, g10, g13;
    g14 = !a0;
    g12 = !(a1 || s7);
    g8  = g14 && s6;
    g15 = g12 || g8;
    g16 = a3 || g8;
    g9  = !(g16 && g15);
    g11 = !(s5 || g9);
    g10 = !(g14 || g11);
    g13 = !(a2 || g12);
    return {!g11, g10, g11, g13};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input logic r, s, i, input logic [N-1:0] e,
                      a, b, c, d);
    exp_t x;
    logic [N-1:0] g17c;
    logic [CL-1:0] nxt;
    logic [3:0] f;
    @(negedge CK);
    RST = r; SE = s; SI = i; EN = e;
    G0 = a; G1 = b; G2 = c; G3 = d;
    nxt = chain;
    for (int k = 0; k < N; k++) begin
      f = s27f(a[k], b[k], c[k], d[k],
               chain[3*k], chain[3*k+1], chain[3*k+2]);
      g17c[k] = f[3];
      if (e[k]) begin
        nxt[3*k]   = f[2];
        nxt[3*k+1] = f[1];
        nxt[3*k+2] = f[0];
      end
    end
    x.chk  = m_known;
    x.g17  = g17c;
    x.g17r = m_g17r;
    x.so   = chain[CL-1];
    x.sig  = m_sig;
    q.push_back(x);
    if (r) begin
      chain = '0; m_g17r = '0; m_sig = '0; m_known = 1;
    end else if (s) begin
      chain = {chain[CL-2:0], i};
    end else begin
      chain  = nxt;
      m_g17r = g17c;
      m_sig  = (m_sig << 1) ^ (m_sig[15] ? 16'h1009 : 16'h0)
               ^ 16'(g17c);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge CK);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        if (x.chk) begin
          check("g17", 32'(G17), 32'(x.g17));
          check("g17_reg", 32'(G17_R), 32'(x.g17r));
          check("so", 32'(SO), 32'(x.so));
          check("so_oreg", 32'(SO_R), 32'(x.so));
`ifdef ISCAS_MISR_EN
          check("sig", 32'(SIG), 32'(x.sig));
          check("sig_oreg", 32'(SIG_R), 32'(x.sig));
`endif
        end
      end
    end
  end

  initial begin : driver
    logic [N-1:0] z, o;
    logic [5:0] pat;
    z = '0; o = '1; pat = 6'b011001;
    chain = 'x; m_g17r = 'x; m_sig = 'x;
    GND = 1'b0; VDD = 1'b1;
    RST = 1'b1; SE = 1'b0; SI = 1'b0;
    EN = z; G0 = z; G1 = z; G2 = z; G3 = z;
    // basic function: expect 101 then evolve
    step(1, 0, 0, z, z, z, z, z);
    step(0, 0, 0, o, o, o, z, z);
    step(0, 0, 0, o, o, o, z, z);
    // G3-only stimulus: state 010, stays
    step(1, 0, 0, z, z, z, z, z);
    step(0, 0, 0, o, z, z, z, o);
    step(0, 0, 0, o, z, z, z, o);
    step(0, 0, 0, o, z, z, z, o);
    // partial enable
    step(1, 0, 0, z, z, z, z, z);
    step(0, 0, 0, 4'b0101, o, o, z, z);
    step(0, 0, 0, z, o, o, z, z);
    // scan 12 bits in then 12 out; EN active but ignored
    for (int k = 0; k < CL; k++)
      step(0, 1, pat[k % 6], o, o, o, z, z);
    for (int k = 0; k < CL; k++)
      step(0, 1, 1'($urandom), o, z, o, o, z);
    // reset in the middle of a shift
    step(0, 0, 0, o, o, o, z, z);
    for (int k = 0; k < 5; k++)
      step(0, 1, 1'b1, o, o, o, z, z);
    step(1, 1, 1'b1, o, o, o, z, z);
    step(0, 1, 1'b0, z, z, z, z, z);
    step(0, 0, 0, z, z, z, z, z);
    // 20 fixed functional cycles, then scan freeze
    step(1, 0, 0, z, z, z, z, z);
    for (int k = 0; k < 20; k++)
      step(0, 0, 0, o, 4'b1010, 4'b0110, 4'b0011, 4'b1001);
    for (int k = 0; k < 4; k++)
      step(0, 1, 1'(k), o, o, o, o, o);
    step(0, 0, 0, o, o, z, z, o);
    // random traffic
    for (int k = 0; k < 400; k++)
      step(($urandom_range(39) == 0), ($urandom_range(3) == 0),
           1'($urandom), N'($urandom), N'($urandom), N'($urandom),
           N'($urandom), N'($urandom));
    @(negedge CK);
    @(negedge CK);
    #4;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
